commit_unit: RTL

- Consumes the ROB head-of-queue commit interface and retires one instruction per cycle.
- Drives register-file writeback and the store-release handshake to the LSU.
- On a taken branch, raises the pipeline flush and the PC redirect.
- Keeps the retired-instruction counter. Sits between `rob` and the regfile/LSU/fetch.

---
 rtl/commit_unit_if.sv | 26 ++
 rtl/commit_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/commit_unit_if.sv
// ROB head-of-queue commit bus: head fields plus valid/ready handshake.
// The ROB drives the master side; the commit unit consumes the slave side.
interface commit_unit_if;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_instr;
    logic [4:0]  commit_rd_addr;
    logic [31:0] commit_result;
    logic        commit_write_enable;
    logic        commit_store_to_mem;
    logic [31:0] commit_new_pc;
    logic        commit_branch_taken;
    logic        commit_ready;

    modport master (
        output commit_valid, commit_pc, commit_instr, commit_rd_addr, commit_result,
               commit_write_enable, commit_store_to_mem, commit_new_pc, commit_branch_taken,
        input  commit_ready
    );

    modport slave (
        input  commit_valid, commit_pc, commit_instr, commit_rd_addr, commit_result,
               commit_write_enable, commit_store_to_mem, commit_new_pc, commit_branch_taken,
        output commit_ready
    );
endinterface

// File: rtl/commit_unit.sv
// Retires the ROB head one per cycle: regfile writeback, store release, branch flush/redirect, instret.
// Latency: every retire effect is a registered output one cycle after the valid&&ready cycle.
// Backpressure: ready drops while awaiting store completion (bounded) and for one flush cycle; COMMIT_TRACE_EN adds trace ports.
module commit_unit #(
    parameter int INSTRET_W     = 64,
    parameter int STORE_TIMEOUT = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    commit_unit_if.slave         commit,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [31:0]          rf_wdata_o,
    output logic                 store_commit_o,
    input  logic                 store_done_i,
    output logic                 flush_o,
    output logic [31:0]          redirect_pc_o,
    output logic [INSTRET_W-1:0] instret_o,
`ifdef COMMIT_TRACE_EN
    output logic                 trace_valid_o,
    output logic [31:0]          trace_pc_o,
    output logic [31:0]          trace_instr_o,
    output logic [4:0]           trace_rd_addr_o,
    output logic [31:0]          trace_result_o,
`endif
    output logic                 store_timeout_o
);

    localparam int WAIT_W = (STORE_TIMEOUT > 1) ? $clog2(STORE_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STORE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STORE_WAIT = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              retire;
    logic              rf_write;

    // Ready is a pure function of state so the ROB never sees a valid->ready loop.
    assign commit.commit_ready = (state == RUN) && !rst_i;
    assign retire   = commit.commit_valid && commit.commit_ready;
    assign rf_write = commit.commit_write_enable && (commit.commit_rd_addr != 5'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= RUN;
            wait_cnt        <= '0;
            rf_we_o         <= 1'b0;
            rf_waddr_o      <= '0;
            rf_wdata_o      <= '0;
            store_commit_o  <= 1'b0;
            flush_o         <= 1'b0;
            redirect_pc_o   <= '0;
            instret_o       <= '0;
            store_timeout_o <= 1'b0;
        end else begin
            rf_we_o        <= 1'b0;
            store_commit_o <= 1'b0;
            flush_o        <= 1'b0;
            case (state)
                RUN: begin
                    if (retire) begin
                        instret_o <= instret_o + INSTRET_W'(1);
                        if (rf_write) begin
                            rf_we_o    <= 1'b1;
                            rf_waddr_o <= commit.commit_rd_addr;
                            rf_wdata_o <= commit.commit_result;
                        end
                        // A store takes precedence; its branch_taken bit is not meaningful.
                        if (commit.commit_store_to_mem) begin
                            store_commit_o <= 1'b1;
                            wait_cnt       <= '0;
                            state          <= STORE_WAIT;
                        end else if (commit.commit_branch_taken) begin
                            flush_o       <= 1'b1;
                            redirect_pc_o <= commit.commit_new_pc;
                            state         <= FLUSH;
                        end
                    end
                end
                STORE_WAIT: begin
                    if (store_done_i) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        store_timeout_o <= 1'b1;
                        state           <= RUN;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                FLUSH: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef COMMIT_TRACE_EN
    // Trace reports every retire regardless of kind, aligned with the other retire effects.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trace_valid_o   <= 1'b0;
            trace_pc_o      <= '0;
            trace_instr_o   <= '0;
            trace_rd_addr_o <= '0;
            trace_result_o  <= '0;
        end else begin
            trace_valid_o <= retire;
            if (retire) begin
                trace_pc_o      <= commit.commit_pc;
                trace_instr_o   <= commit.commit_instr;
                trace_rd_addr_o <= commit.commit_rd_addr;
                trace_result_o  <= commit.commit_result;
            end
        end
    end
`else
    logic unused_trace_fields;
    assign unused_trace_fields = ^{commit.commit_pc, commit.commit_instr};
`endif

endmodule
